instruction_frame_assembler: RTL and testbench

//  Sits between spi_byte_if and instruction_handler-side logic: collects received SPI bytes into

---
 rtl/instruction_frame_assembler.sv | 176 +++++++++++++++++
 tb/tb_instruction_frame_assembler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_frame_assembler.sv
// Collects SPI bytes into instruction frames {opcode, 24b address, 32b value}
// and presents each completed frame once on a valid/ready output. The frame
// length depends on the opcode. A frame is aborted if chip select is released
// or the byte stream stalls too long. A byte that arrives while a frame is
// still waiting to be accepted is dropped and flagged.
module instruction_frame_assembler #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
   parameter logic [7:0]  OP_WRITE       = 8'h01,
   parameter logic [7:0]  OP_READ        = 8'h02,
   parameter logic [7:0]  OP_STREAM      = 8'h03
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        cs_n_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_byte_i,
   input  logic        frame_ready_i,
   output logic        frame_valid_o,
   output logic [7:0]  instruction_o,
   output logic [23:0] address_o,
   output logic [31:0] value_o,
   output logic        err_opcode_o,
   output logic        err_overflow_o,
   output logic        err_timeout_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      VALUE = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t      state;
   logic [7:0]  op_sh;
   logic [23:0] addr_sh;
   logic [31:0] val_sh;
   logic [1:0]  byte_cnt;
   logic [23:0] tmo_cnt;

   logic rx_take;
   logic op_frame;
   logic op_bad;
   logic tmo_hit;
   logic abort;
   logic handshake;

   // Opcodes that open a multi-byte frame; everything else is NOP or unknown.
   function automatic logic is_frame_op(input logic [7:0] op);
      return (op == OP_WRITE) || (op == OP_READ) || (op == OP_STREAM);
   endfunction

   // Decode of the incoming byte and the abort/handshake conditions.
   always_comb begin
      rx_take   = rx_valid_i && !cs_n_i;
      op_frame  = is_frame_op(rx_byte_i);
      op_bad    = !op_frame && (rx_byte_i != 8'h00);
      tmo_hit   = (TIMEOUT_CYCLES != 24'd0) && (tmo_cnt >= TIMEOUT_CYCLES);
      abort     = cs_n_i || tmo_hit;
      handshake = frame_valid_o && frame_ready_i;
   end

   // Frame assembly FSM; the output frame registers are loaded only when a
   // frame completes, so they keep the last delivered frame during assembly.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         op_sh          <= 8'h00;
         addr_sh        <= 24'h000000;
         val_sh         <= 32'h0000_0000;
         byte_cnt       <= 2'd0;
         tmo_cnt        <= 24'd0;
         frame_valid_o  <= 1'b0;
         instruction_o  <= 8'h00;
         address_o      <= 24'h000000;
         value_o        <= 32'h0000_0000;
         err_opcode_o   <= 1'b0;
         err_overflow_o <= 1'b0;
         err_timeout_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tmo_cnt <= 24'd0;
               if (rx_take) begin
                  op_sh <= rx_byte_i;
                  if (op_frame) begin
                     state    <= ADDR;
                     byte_cnt <= 2'd0;
                     addr_sh  <= 24'h000000;
                  end else if (op_bad) begin
                     err_opcode_o <= 1'b1;
                  end
               end
            end

            ADDR: begin
               if (abort) begin
                  // Abort beats a coincident byte: the partial frame is discarded.
                  state         <= IDLE;
                  tmo_cnt       <= 24'd0;
                  err_timeout_o <= 1'b1;
               end else if (rx_valid_i) begin
                  tmo_cnt <= 24'd0;
                  addr_sh <= {addr_sh[15:0], rx_byte_i};
                  if (byte_cnt == 2'd2) begin
                     byte_cnt <= 2'd0;
                     if (op_sh == OP_WRITE) begin
                        state  <= VALUE;
                        val_sh <= 32'h0000_0000;
                     end else begin
                        state         <= HOLD;
                        frame_valid_o <= 1'b1;
                        instruction_o <= op_sh;
                        address_o     <= {addr_sh[15:0], rx_byte_i};
                        value_o       <= 32'h0000_0000;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end else if (tmo_cnt != 24'hFF_FFFF) begin
                  tmo_cnt <= tmo_cnt + 24'd1;
               end
            end

            VALUE: begin
               if (abort) begin
                  state         <= IDLE;
                  tmo_cnt       <= 24'd0;
                  err_timeout_o <= 1'b1;
               end else if (rx_valid_i) begin
                  tmo_cnt <= 24'd0;
                  val_sh  <= {val_sh[23:0], rx_byte_i};
                  if (byte_cnt == 2'd3) begin
                     byte_cnt      <= 2'd0;
                     state         <= HOLD;
                     frame_valid_o <= 1'b1;
                     instruction_o <= op_sh;
                     address_o     <= addr_sh;
                     value_o       <= {val_sh[23:0], rx_byte_i};
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end else if (tmo_cnt != 24'hFF_FFFF) begin
                  tmo_cnt <= tmo_cnt + 24'd1;
               end
            end

            HOLD: begin
               // Chip select is ignored here: a completed frame is always delivered.
               tmo_cnt <= 24'd0;
               if (handshake) begin
                  frame_valid_o <= 1'b0;
                  err_opcode_o  <= 1'b0;
                  state         <= IDLE;
                  // A byte arriving with the handshake starts the next frame.
                  if (rx_take) begin
                     op_sh <= rx_byte_i;
                     if (op_frame) begin
                        state    <= ADDR;
                        byte_cnt <= 2'd0;
                        addr_sh  <= 24'h000000;
                     end else if (op_bad) begin
                        err_opcode_o <= 1'b1;
                     end
                  end
               end else if (rx_take) begin
                  err_overflow_o <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_frame_assembler.sv
// Directed bench for instruction_frame_assembler: expected frames are queued
// as bytes are sent and compared when the DUT hands a frame over.
module tb_instruction_frame_assembler;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic        cs_n_i;
   logic        rx_valid_i;
   logic [7:0]  rx_byte_i;
   logic        frame_ready_i;
   logic        frame_valid_o;
   logic [7:0]  instruction_o;
   logic [23:0] address_o;
   logic [31:0] value_o;
   logic        err_opcode_o;
   logic        err_overflow_o;
   logic        err_timeout_o;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   instruction_frame_assembler #(
      .TIMEOUT_CYCLES(24'd16)
   ) dut (
      .clk_i          (clk_i),
      .rst_n          (rst_n),
      .cs_n_i         (cs_n_i),
      .rx_valid_i     (rx_valid_i),
      .rx_byte_i      (rx_byte_i),
      .frame_ready_i  (frame_ready_i),
      .frame_valid_o  (frame_valid_o),
      .instruction_o  (instruction_o),
      .address_o      (address_o),
      .value_o        (value_o),
      .err_opcode_o   (err_opcode_o),
      .err_overflow_o (err_overflow_o),
      .err_timeout_o  (err_timeout_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid_i = 1'b1;
      rx_byte_i  = b;
      step();
      rx_valid_i = 1'b0;
      rx_byte_i  = 8'h00;
   endtask

   // Scoreboard: every accepted frame must match the oldest expected frame.
   always @(negedge clk_i) begin
      if (rst_n && frame_valid_o && frame_ready_i) begin
         if (exp_q.size() == 0)
            chk("unexpected_frame", 64'(exp_q.size()), 64'd1);
         else
            chk("frame", {instruction_o, address_o, value_o}, exp_q.pop_front());
      end
   end

   initial begin
      rst_n         = 1'b0;
      cs_n_i        = 1'b0;
      rx_valid_i    = 1'b0;
      rx_byte_i     = 8'h00;
      frame_ready_i = 1'b1;
      step();
      step();
      chk("rst_valid", 64'(frame_valid_o), 64'd0);
      chk("rst_frame", {instruction_o, address_o, value_o}, 64'd0);
      chk("rst_errs", 64'({err_opcode_o, err_overflow_o, err_timeout_o}), 64'd0);
      rst_n = 1'b1;
      step();

      // WRITE frame, consumer always ready
      exp_q.push_back({8'h01, 24'h000010, 32'hDEADBEEF});
      send(8'h01); send(8'h00); send(8'h00); send(8'h10);
      send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
      chk("wr_latency", 64'(frame_valid_o), 64'd1);
      step();
      chk("wr_drop", 64'(frame_valid_o), 64'd0);

      // READ frame held while consumer stalls
      frame_ready_i = 1'b0;
      exp_q.push_back({8'h02, 24'h123456, 32'h0});
      send(8'h02); send(8'h12); send(8'h34); send(8'h56);
      for (int i = 0; i < 5; i++) begin
         chk("rd_hold_valid", 64'(frame_valid_o), 64'd1);
         chk("rd_hold_frame", {instruction_o, address_o, value_o}, {8'h02, 24'h123456, 32'h0});
         step();
      end
      frame_ready_i = 1'b1;
      step();
      chk("rd_drop", 64'(frame_valid_o), 64'd0);

      // Overflow: extra byte while a frame is pending
      frame_ready_i = 1'b0;
      exp_q.push_back({8'h02, 24'hABCDEF, 32'h0});
      send(8'h02); send(8'hAB); send(8'hCD); send(8'hEF);
      chk("ovf_clear", 64'(err_overflow_o), 64'd0);
      send(8'h02);
      chk("ovf_set", 64'(err_overflow_o), 64'd1);
      chk("ovf_valid", 64'(frame_valid_o), 64'd1);
      chk("ovf_frame", {instruction_o, address_o, value_o}, {8'h02, 24'hABCDEF, 32'h0});
      frame_ready_i = 1'b1;
      step();
      chk("ovf_drop", 64'(frame_valid_o), 64'd0);

      // CS abort mid-address, then STREAM frame
      send(8'h01); send(8'h00); send(8'h00);
      cs_n_i = 1'b1;
      step();
      chk("cs_abort_err", 64'(err_timeout_o), 64'd1);
      chk("cs_abort_valid", 64'(frame_valid_o), 64'd0);
      chk("cs_abort_keep", 64'(address_o), 64'hABCDEF);
      send(8'h7F);
      chk("cs_high_ignored", 64'(err_opcode_o), 64'd0);
      cs_n_i = 1'b0;
      exp_q.push_back({8'h03, 24'h000007, 32'h0});
      send(8'h03); send(8'h00); send(8'h00); send(8'h07);
      step();
      chk("stream_done", 64'(frame_valid_o), 64'd0);
      chk("q_empty_1", 64'(exp_q.size()), 64'd0);

      // Reset during VALUE phase
      send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(frame_valid_o), 64'd0);
      chk("mid_rst_frame", {instruction_o, address_o, value_o}, 64'd0);
      chk("mid_rst_errs", 64'({err_opcode_o, err_overflow_o, err_timeout_o}), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      exp_q.push_back({8'h01, 24'hA1B2C3, 32'h01234567});
      send(8'h01); send(8'hA1); send(8'hB2); send(8'hC3);
      send(8'h01); send(8'h23); send(8'h45); send(8'h67);
      chk("post_rst_valid", 64'(frame_valid_o), 64'd1);
      step();
      chk("post_rst_drop", 64'(frame_valid_o), 64'd0);

      // NOP, then a byte coincident with the handshake starts the next frame
      send(8'h00);
      chk("nop_err", 64'(err_opcode_o), 64'd0);
      chk("nop_valid", 64'(frame_valid_o), 64'd0);
      frame_ready_i = 1'b0;
      exp_q.push_back({8'h02, 24'h000102, 32'h0});
      send(8'h02); send(8'h00); send(8'h01); send(8'h02);
      chk("coin_pending", 64'(frame_valid_o), 64'd1);
      exp_q.push_back({8'h02, 24'h0A0B0C, 32'h0});
      frame_ready_i = 1'b1;
      send(8'h02);
      chk("coin_accept", 64'(frame_valid_o), 64'd0);
      send(8'h0A); send(8'h0B); send(8'h0C);
      chk("coin_next", 64'(frame_valid_o), 64'd1);
      step();
      chk("coin_no_ovf", 64'(err_overflow_o), 64'd0);
      chk("q_empty_2", 64'(exp_q.size()), 64'd0);

      // 15 idle cycles between bytes stays within the timeout
      exp_q.push_back({8'h01, 24'hAABBCC, 32'h11223344});
      send(8'h01); send(8'hAA);
      repeat (15) step();
      send(8'hBB); send(8'hCC);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      step();
      chk("tmo_15_ok", 64'(err_timeout_o), 64'd0);

      // 17 idle cycles aborts the frame
      send(8'h01); send(8'hAA);
      repeat (17) step();
      chk("tmo_17_err", 64'(err_timeout_o), 64'd1);
      chk("tmo_17_valid", 64'(frame_valid_o), 64'd0);
      send(8'h7F);
      chk("bad_opcode", 64'(err_opcode_o), 64'd1);
      exp_q.push_back({8'h02, 24'h000001, 32'h0});
      send(8'h02); send(8'h00); send(8'h00); send(8'h01);
      step();
      chk("opcode_err_cleared", 64'(err_opcode_o), 64'd0);
      chk("tmo_sticky", 64'(err_timeout_o), 64'd1);
      chk("q_empty_3", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
